// File: rtl/ic_test_controller.sv
// ic_test_controller: sequences one gate-checker test.
// Flow: start edge -> ARM (checker clears its verdicts) -> RUN (wait for all
// four verdicts) -> SETTLE (one fresh checker round) -> DONE, with TOUT if the
// verdicts never complete and abort back to IDLE.
module ic_test_controller #(
  parameter int unsigned ROUND_CYCLES   = 200000004,
  parameter int unsigned TIMEOUT_CYCLES = 400000008
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] gate_sw,
  input  logic       pass1,
  input  logic       pass2,
  input  logic       pass3,
  input  logic       pass4,
  input  logic       fail1,
  input  logic       fail2,
  input  logic       fail3,
  input  logic       fail4,
  output logic       enable,
  output logic [2:0] gateSelect,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [3:0] gate_pass,
  output logic [3:0] gate_fail,
  output logic       all_pass
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_SETTLE,
    S_DONE,
    S_TOUT
  } state_t;

  // Terminal count of each timed state; the counter restarts at 0 on entry.
  localparam logic [31:0] ARM_LAST    = 32'd1;
  localparam logic [31:0] RUN_LAST    = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(ROUND_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [31:0] cnt;

  logic        start_q;
  logic        start_blk;
  logic        start_rise;
  logic        gate_ok;
  logic [3:0]  pass_vec;
  logic [3:0]  fail_vec;
  logic        verdict_all;

  logic        load_test;
  logic        clear_results;
  logic        sample_results;

  assign pass_vec    = {pass4, pass3, pass2, pass1};
  assign fail_vec    = {fail4, fail3, fail2, fail1};
  assign verdict_all = &(pass_vec | fail_vec);
  assign gate_ok     = (gate_sw <= 3'd5);

  // start_blk keeps a start level that was already high during reset from
  // being seen as a fresh request once reset is released; it clears the first
  // time start is observed low.
  assign start_rise  = start & ~start_q & ~start_blk;

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode, Moore outputs and datapath strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_next     = state;
    load_test      = 1'b0;
    clear_results  = 1'b0;
    sample_results = 1'b0;
    enable         = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    timeout        = 1'b0;

    case (state)
      S_IDLE, S_DONE, S_TOUT: begin
        done    = (state == S_DONE);
        timeout = (state == S_TOUT);
        // Invalid gate codes leave the controller exactly where it was.
        if (start_rise && gate_ok) begin
          state_next = S_ARM;
          load_test  = 1'b1;
        end
      end
      S_ARM: begin
        busy = 1'b1;
        if (abort) begin
          state_next    = S_IDLE;
          clear_results = 1'b1;
        end else if (cnt == ARM_LAST) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy   = 1'b1;
        enable = 1'b1;
        if (abort) begin
          state_next    = S_IDLE;
          clear_results = 1'b1;
        end else if (verdict_all) begin
          state_next = S_SETTLE;
        end else if (cnt == RUN_LAST) begin
          state_next = S_TOUT;
        end
      end
      S_SETTLE: begin
        busy   = 1'b1;
        enable = 1'b1;
        if (abort) begin
          state_next    = S_IDLE;
          clear_results = 1'b1;
        end else if (cnt == SETTLE_LAST) begin
          state_next     = S_DONE;
          sample_results = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Per-state cycle counter: cleared on every state change, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 32'd0;
    end else if (state_next != state) begin
      cnt <= 32'd0;
    end else if (cnt != 32'hFFFF_FFFF) begin
      cnt <= cnt + 32'd1;
    end
  end

  // Start edge detector and post-reset blocking of a held start level.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q   <= 1'b0;
      start_blk <= start;
    end else begin
      start_q   <= start;
      start_blk <= start_blk & start;
    end
  end

  // Gate code and verdict registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      gateSelect <= 3'd0;
      gate_pass  <= 4'b0000;
      gate_fail  <= 4'b0000;
      all_pass   <= 1'b0;
    end else if (load_test) begin
      gateSelect <= gate_sw;
      gate_pass  <= 4'b0000;
      gate_fail  <= 4'b0000;
      all_pass   <= 1'b0;
    end else if (clear_results) begin
      gate_pass  <= 4'b0000;
      gate_fail  <= 4'b0000;
      all_pass   <= 1'b0;
    end else if (sample_results) begin
      gate_pass  <= pass_vec;
      gate_fail  <= fail_vec;
      // A gate reporting both pass and fail is contradictory, so it can never
      // count towards an overall pass even though both bits are kept.
      all_pass   <= (&pass_vec) & ~(|(pass_vec & fail_vec));
    end
  end

endmodule

// File: tb/tb_ic_test_controller.sv
// Bench for ic_test_controller: table of directed tests, hand-written abort and
// reset sequences, then randomized tests predicted by a transaction-level model.
module tb_ic_test_controller;

  localparam int ROUND   = 8;
  localparam int TIMEOUT = 64;
  localparam int BOUND   = 300;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [2:0] gate_sw;
  logic       pass1, pass2, pass3, pass4;
  logic       fail1, fail2, fail3, fail4;
  logic       enable;
  logic [2:0] gateSelect;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [3:0] gate_pass;
  logic [3:0] gate_fail;
  logic       all_pass;

  int checks = 0;
  int errors = 0;

  ic_test_controller #(
    .ROUND_CYCLES  (ROUND),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .gate_sw   (gate_sw),
    .pass1     (pass1),
    .pass2     (pass2),
    .pass3     (pass3),
    .pass4     (pass4),
    .fail1     (fail1),
    .fail2     (fail2),
    .fail3     (fail3),
    .fail4     (fail4),
    .enable    (enable),
    .gateSelect(gateSelect),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .gate_pass (gate_pass),
    .gate_fail (gate_fail),
    .all_pass  (all_pass)
  );

  always #5 clk = ~clk;

  // One test: gate code, first RUN cycle in which the checker has a complete
  // verdict, the fresh verdict seen during SETTLE, and the expected outcome.
  typedef struct {
    logic [2:0] gate;
    int         delay;
    logic [3:0] fp;
    logic [3:0] ff;
    logic       exp_done;
    logic       exp_tout;
    logic [3:0] exp_gp;
    logic [3:0] exp_gf;
    logic       exp_ap;
    logic [2:0] exp_sel;
    int         exp_en;
    int         exp_busy;
  } vec_t;

  vec_t tbl[8];
  vec_t model;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_verdicts(input logic [3:0] p, input logic [3:0] f);
    {pass4, pass3, pass2, pass1} = p;
    {fail4, fail3, fail2, fail1} = f;
  endtask

  // Outcome from the rules: ARM is 2 cycles, RUN lasts until the verdict is
  // complete or TIMEOUT cycles elapse, SETTLE is one ROUND; invalid codes
  // leave every output as it was.
  function automatic vec_t predict(input logic [2:0] g, input int d,
                                   input logic [3:0] fp, input logic [3:0] ff,
                                   input vec_t prev);
    vec_t r;
    r       = prev;
    r.gate  = g;
    r.delay = d;
    r.fp    = fp;
    r.ff    = ff;
    if (g > 3'd5) begin
      r.exp_en   = 0;
      r.exp_busy = 0;
    end else if (d < TIMEOUT) begin
      r.exp_done = 1'b1;
      r.exp_tout = 1'b0;
      r.exp_gp   = fp;
      r.exp_gf   = ff;
      r.exp_ap   = (fp == 4'hF) && ((fp & ff) == 4'h0);
      r.exp_sel  = g;
      r.exp_en   = d + 1 + ROUND;
      r.exp_busy = r.exp_en + 2;
    end else begin
      r.exp_done = 1'b0;
      r.exp_tout = 1'b1;
      r.exp_gp   = 4'h0;
      r.exp_gf   = 4'h0;
      r.exp_ap   = 1'b0;
      r.exp_sel  = g;
      r.exp_en   = TIMEOUT;
      r.exp_busy = TIMEOUT + 2;
    end
    return r;
  endfunction

  // Pulse start, act as the checker, then compare the observed test.
  task automatic run_test(input string tag, input vec_t v);
    int en_cnt;
    int busy_cnt;
    int cyc;
    int k;
    logic [3:0] p;
    logic [3:0] f;
    en_cnt   = 0;
    busy_cnt = 0;
    cyc      = 0;
    start    = 1'b0;
    abort    = 1'b0;
    gate_sw  = v.gate;
    set_verdicts(4'h0, 4'h0);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < BOUND) begin
      if (enable) en_cnt++;
      if (busy) busy_cnt++;
      if (cyc >= 3 && !busy) break;
      if (en_cnt <= v.delay) begin
        // Incomplete: at least one gate has neither verdict.
        p = 4'($urandom);
        f = 4'($urandom);
        k = $urandom_range(0, 3);
        p[k] = 1'b0;
        f[k] = 1'b0;
      end else if (en_cnt <= v.delay + 4) begin
        // Complete but stale; must not be what gets latched.
        p = 4'($urandom);
        f = ~p;
      end else begin
        p = v.fp;
        f = v.ff;
      end
      set_verdicts(p, f);
      if (busy) gate_sw = 3'($urandom_range(0, 7));
      step();
      cyc++;
    end
    check({tag, " bound"}, 32'(cyc < BOUND), 32'd1);
    check({tag, " enable_cycles"}, en_cnt, v.exp_en);
    check({tag, " busy_cycles"}, busy_cnt, v.exp_busy);
    check({tag, " enable_end"}, enable, 1'b0);
    check({tag, " done"}, done, v.exp_done);
    check({tag, " timeout"}, timeout, v.exp_tout);
    check({tag, " gate_pass"}, gate_pass, v.exp_gp);
    check({tag, " gate_fail"}, gate_fail, v.exp_gf);
    check({tag, " all_pass"}, all_pass, v.exp_ap);
    check({tag, " gateSelect"}, gateSelect, v.exp_sel);
  endtask

  initial begin
    int n;
    vec_t r;
    logic [2:0] g;
    int d;

    // gate, delay, fresh pass, fresh fail, done, tout, gp, gf, ap, sel, en, busy
    tbl[0] = '{3'd2, 10,  4'hF, 4'h0, 1'b1, 1'b0, 4'hF, 4'h0, 1'b1, 3'd2, 19, 21};
    tbl[1] = '{3'd4, 3,   4'hB, 4'h4, 1'b1, 1'b0, 4'hB, 4'h4, 1'b0, 3'd4, 12, 14};
    tbl[2] = '{3'd0, 100, 4'hF, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 3'd0, 64, 66};
    tbl[3] = '{3'd5, 0,   4'hF, 4'h2, 1'b1, 1'b0, 4'hF, 4'h2, 1'b0, 3'd5, 9,  11};
    tbl[4] = '{3'd7, 0,   4'h0, 4'h0, 1'b1, 1'b0, 4'hF, 4'h2, 1'b0, 3'd5, 0,  0};
    tbl[5] = '{3'd1, 62,  4'h5, 4'hA, 1'b1, 1'b0, 4'h5, 4'hA, 1'b0, 3'd1, 71, 73};
    tbl[6] = '{3'd3, 64,  4'hF, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 3'd3, 64, 66};
    tbl[7] = '{3'd6, 0,   4'hF, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 3'd3, 0,  0};

    reset   = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    gate_sw = 3'd0;
    set_verdicts(4'h0, 4'h0);
    step();
    step();
    check("reset enable", enable, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset timeout", timeout, 1'b0);
    check("reset all_pass", all_pass, 1'b0);
    check("reset gateSelect", gateSelect, 3'd0);
    check("reset gate_pass", gate_pass, 4'h0);
    check("reset gate_fail", gate_fail, 4'h0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      run_test($sformatf("tbl%0d", i), tbl[i]);
      model = tbl[i];
    end

    // Abort and a new start edge together in RUN cycle 5.
    start   = 1'b0;
    gate_sw = 3'd3;
    set_verdicts(4'h0, 4'h0);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!enable && n < 10) begin
      step();
      n++;
    end
    repeat (5) step();
    check("abort pre enable", enable, 1'b1);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    check("abort busy", busy, 1'b0);
    check("abort enable", enable, 1'b0);
    check("abort done", done, 1'b0);
    check("abort timeout", timeout, 1'b0);
    check("abort gateSelect", gateSelect, 3'd3);
    repeat (3) step();
    check("abort start ignored", busy, 1'b0);
    start = 1'b0;
    step();
    gate_sw = 3'd1;
    start   = 1'b1;
    step();
    start = 1'b0;
    check("later start busy", busy, 1'b1);
    check("later start gateSelect", gateSelect, 3'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort in arm", busy, 1'b0);

    // Reset in the middle of SETTLE with start held through reset release.
    gate_sw = 3'd4;
    set_verdicts(4'hF, 4'h0);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    check("settle enable", enable, 1'b1);
    check("settle busy", busy, 1'b1);
    reset = 1'b1;
    start = 1'b1;
    step();
    check("rst settle enable", enable, 1'b0);
    check("rst settle busy", busy, 1'b0);
    check("rst settle done", done, 1'b0);
    check("rst settle all_pass", all_pass, 1'b0);
    check("rst settle gateSelect", gateSelect, 3'd0);
    check("rst settle gate_pass", gate_pass, 4'h0);
    reset = 1'b0;
    repeat (4) step();
    check("held start no launch", busy, 1'b0);
    start = 1'b0;
    step();
    gate_sw = 3'd2;
    start   = 1'b1;
    step();
    start = 1'b0;
    check("post reset start busy", busy, 1'b1);
    check("post reset gateSelect", gateSelect, 3'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    model          = '{3'd2, 0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 3'd2, 0, 0};

    // Randomized tests against the model.
    for (int i = 0; i < 25; i++) begin
      g = 3'($urandom_range(0, 7));
      d = $urandom_range(0, 70);
      if (d == TIMEOUT - 1) d = TIMEOUT - 2;
      r = predict(g, d, 4'($urandom), 4'($urandom), model);
      run_test($sformatf("rnd%0d", i), r);
      model = r;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ic_test_controller.md
IC_TEST_CONTROLLER -- requirements
Module: ic_test_controller

Interface
REQ-001 Parameter ROUND_CYCLES, default 200000004: one full four-pattern checker round, in clk cycles.
REQ-002 Parameter TIMEOUT_CYCLES, default 400000008: maximum wait in RUN for a complete verdict.
REQ-003 Ports: clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high; sampled on rising clk.
REQ-005 start  in  1  level request from the board; a test begins on its rising edge only.
REQ-006 abort  in  1  level; cancels a running test.
REQ-007 gate_sw  in  3  gate-type selection switches: 0=AND, 1=OR, 2=NAND, 3=NOR, 4=XOR, 5=XNOR.
REQ-008 pass1..pass4, fail1..fail4  in  1 each  per-gate verdicts from the two-input checker.
REQ-009 enable  out  1  run enable to the checker.
REQ-010 gateSelect  out  3  gate code to the checker, frozen for the whole test.
REQ-011 busy  out  1  high in ARM, RUN and SETTLE.
REQ-012 done  out  1  high in DONE; result outputs are valid.
REQ-013 timeout  out  1  high in TOUT.
REQ-014 gate_pass, gate_fail  out  4 each  latched per-gate verdicts; bit i-1 corresponds to gate i.
REQ-015 all_pass  out  1  high when all four latched gate_pass bits are set.

Function
REQ-016 FSM states SHALL be IDLE, ARM, RUN, SETTLE, DONE and TOUT, and SHALL be one-hot or binary encoded with no other reachable state.
REQ-017 Start detection SHALL use a registered copy of start; start_rise is start high while the registered copy is low.
REQ-018 IDLE/DONE/TOUT: start_rise SHALL latch gate_sw into gateSelect and clear gate_pass, gate_fail, all_pass, done and timeout, then go to ARM.
REQ-019 gate_sw values 6 and 7 SHALL be rejected: the FSM stays in its current state and the outputs are unchanged.
REQ-020 ARM SHALL hold enable low for exactly 2 cycles, so the checker clears its verdicts, then go to RUN.
REQ-021 RUN SHALL hold enable high and count cycles from 0.
- When (pass_i|fail_i) is 1 for all i=1..4, go to SETTLE and reset the counter.
- When the count reaches TIMEOUT_CYCLES-1 first, go to TOUT.
REQ-022 SETTLE SHALL keep enable high for exactly ROUND_CYCLES cycles, discarding the checker's first, stale verdict, then sample pass1..4 into gate_pass and fail1..4 into gate_fail, and go to DONE.
REQ-023 all_pass SHALL equal &gate_pass and SHALL be registered in the same cycle as gate_pass.
REQ-024 DONE and TOUT SHALL drive enable low; results SHALL hold until the next accepted start or reset.
REQ-025 abort high in ARM, RUN or SETTLE SHALL go to IDLE next cycle with enable low and results cleared.
REQ-026 abort SHALL take priority over start_rise and over any RUN/SETTLE transition in the same cycle.
REQ-027 start_rise while busy SHALL be ignored, and gateSelect SHALL NOT change while busy.
REQ-028 Counters SHALL be 32-bit unsigned, SHALL never wrap, and SHALL reset to 0 on every state entry.
REQ-029 If gate_pass[i] and gate_fail[i] are both 1, the controller SHALL latch them as received and SHALL still deassert all_pass.

Reset
REQ-030 On reset the FSM SHALL be in IDLE and enable, busy, done, timeout and all_pass SHALL be 0.
REQ-031 On reset gateSelect SHALL be 0, gate_pass and gate_fail SHALL be 4'b0000, the counters SHALL be 0, and the registered start SHALL be 0.
REQ-032 Reset SHALL override every state, including mid-RUN and mid-SETTLE, and SHALL take effect in the cycle it is sampled.

Verification (ROUND_CYCLES=8, TIMEOUT_CYCLES=64)
REQ-033 gate_sw=2, start pulse, model asserts pass1..4 ten cycles after enable -> enable high 8 more cycles, then done=1, gate_pass=4'b1111, all_pass=1, gateSelect=2.
REQ-034 Model asserts pass1,pass2,fail3,pass4 -> gate_pass=4'b1011, gate_fail=4'b0100, all_pass=0, done=1.
REQ-035 Verdicts never asserted -> timeout=1 exactly 64 cycles after RUN entry, enable=0, done=0.
REQ-036 abort and start rising together at RUN cycle 5 -> IDLE next cycle, enable=0; the new start is ignored; a later start is accepted.
REQ-037 gate_sw=7 start -> stays IDLE, enable=0; gate_sw change during RUN -> gateSelect unchanged.
REQ-038 reset asserted mid-SETTLE -> all outputs at reset values next cycle; start held high through reset deassert does not launch a test.
